// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SEQ unified-memory port arbiter: FSM state and
// transaction-owner encodings, plus the counter sizing helper.
package mem_port_arbiter_pkg;

    // FSM states of the single outstanding memory transaction.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Latency counter width; MEM_LAT is limited to 1..15.
    localparam int LAT_W = 4;

    // Width of a saturating counter that must reach starve_max.
    function automatic int starve_w(input int starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals of the port arbiter.
// slave  : the arbiter itself.
// master : the surrounding pipeline / memory model that talks to it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    // Instruction-fetch port
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rdata;

    // Unified memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req_valid, if_addr, if_flush,
        input  d_req_valid, d_we, d_addr, d_wdata, d_wmask,
        input  mem_rdata,
        output if_req_ready, if_rsp_valid, if_rdata,
        output d_req_ready, d_rsp_valid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        output busy
    );

    modport master (
        output if_req_valid, if_addr, if_flush,
        output d_req_valid, d_we, d_addr, d_wdata, d_wmask,
        output mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rdata,
        input  d_req_ready, d_rsp_valid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  busy
    );

endinterface

// File: rtl/mem_arb_picker.sv
// Winner selection between fetch and data requests. Data normally wins;
// after STARVE_MAX consecutive data grants with fetch waiting, fetch wins.
module mem_arb_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   if_req_valid,
    input  logic   d_req_valid,
    input  logic   grant,
    input  owner_e grant_owner,
    input  logic   in_idle,
    output owner_e winner,
    output logic   win_valid
);

    localparam int            SW         = starve_w(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    // Pick the requester that gets ready this cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        winner    = OWN_IF;
        win_valid = in_idle && (if_req_valid || d_req_valid);
        if (d_req_valid && !(if_req_valid && (starve_cnt == STARVE_LIM)))
            winner = OWN_D;
    end

    // Count data grants that bypassed a waiting fetch; saturate at the limit.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst) begin
            starve_cnt <= '0;
        end else if (in_idle) begin
            if (!if_req_valid || (grant && (grant_owner == OWN_IF)))
                starve_cnt <= '0;
            else if (grant && (grant_owner == OWN_D) && (starve_cnt != STARVE_LIM))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between instruction fetch and
// load/store. One transaction at a time: IDLE -> ISSUE -> WAIT x MEM_LAT
// -> RESP, with registered memory control and a one-cycle response pulse.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int               MASK_W   = DATA_W / 8;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

    arb_state_e        state, next_state;
    owner_e            owner_q;
    owner_e            winner;
    logic              win_valid;
    logic              in_idle;
    logic              if_ready, d_ready;
    logic              grant;
    logic [LAT_W-1:0]  lat_cnt;
    logic              wait_last;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              mem_en_q, mem_we_q;
    logic [DATA_W-1:0] rdata_q;
    logic              drop_q;

    assign in_idle   = (state == IDLE);
    assign wait_last = (state == WAIT) && (lat_cnt == LAT_LAST);

    mem_arb_picker #(
        .STARVE_MAX (STARVE_MAX)
    ) u_picker (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (bus.if_req_valid),
        .d_req_valid  (bus.d_req_valid),
        .grant        (grant),
        .grant_owner  (winner),
        .in_idle      (in_idle),
        .winner       (winner),
        .win_valid    (win_valid)
    );

    // Ready only to the IDLE winner while its valid is high. Gated by rst
    // so every output reads 0 while reset is held, even with valid high.
    always_comb begin
        if_ready = 1'b0;
        d_ready  = 1'b0;
        if (rst && win_valid) begin
            if (winner == OWN_IF) if_ready = bus.if_req_valid;
            else                  d_ready  = bus.d_req_valid;
        end
    end

    assign grant = (if_ready && bus.if_req_valid) || (d_ready && bus.d_req_valid);

    // Next-state logic of the transaction FSM.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (grant) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_last) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Capture the winner's payload on the grant edge; it then drives memory.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: payload flops are reset even though they are always written
        // before use, because every memory-side output must read 0 in reset.
        if (!rst) begin
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (grant) begin
            owner_q <= winner;
            if (winner == OWN_D) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                wmask_q <= bus.d_wmask;
            end else begin
                // Fetch is always a read with no byte enables.
                we_q    <= 1'b0;
                addr_q  <= bus.if_addr;
                wmask_q <= '0;
            end
        end
    end

    // Registered memory strobes: high for the single ISSUE cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
        end else begin
            mem_en_q <= (next_state == ISSUE);
            mem_we_q <= (next_state == ISSUE) && (winner == OWN_D) && bus.d_we;
        end
    end

    // Latency counter: cleared in ISSUE, counts WAIT cycles up to MEM_LAT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 lat_cnt <= '0;
        else if (state == ISSUE)  lat_cnt <= '0;
        else if (state == WAIT)   lat_cnt <= lat_cnt + LAT_W'(1);
    end

    // Response data: memory data on the last WAIT edge, 0 for stores.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata_q <= '0;
        else if (wait_last)
            rdata_q <= ((owner_q == OWN_D) && we_q) ? '0 : bus.mem_rdata;
    end

    // Drop flag: a flush during an in-flight fetch swallows its response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_q <= 1'b0;
        else if (state == RESP)
            drop_q <= 1'b0;
        else if (!in_idle && (owner_q == OWN_IF) && bus.if_flush)
            drop_q <= 1'b1;
    end

    assign bus.if_req_ready = if_ready;
    assign bus.d_req_ready  = d_ready;

    // A flush in the RESP cycle itself suppresses the pulse combinationally.
    assign bus.if_rsp_valid = (state == RESP) && (owner_q == OWN_IF) && !drop_q && !bus.if_flush;
    assign bus.d_rsp_valid  = (state == RESP) && (owner_q == OWN_D);
    assign bus.if_rdata     = rdata_q;
    assign bus.d_rdata      = rdata_q;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

    assign bus.busy = !in_idle;

endmodule
